// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: ctrl codes, slice op codes, FSM states
// and the ctrl decoder used when a request is accepted.
`timescale 1ns/1ps
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
    logic       arith;  // ADD/SUB: carry-out and overflow are reported
    logic       slt;
    logic       valid;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] ctrl);
    dec_t d;
    d = '{a_inv: 1'b0, b_inv: 1'b0, op: OP_AND, arith: 1'b0, slt: 1'b0, valid: 1'b1};
    case (ctrl)
      ALU_AND: d.op = OP_AND;
      ALU_OR:  d.op = OP_OR;
      ALU_ADD: begin d.op = OP_ADD; d.arith = 1'b1; end
      ALU_SUB: begin d.op = OP_ADD; d.b_inv = 1'b1; d.arith = 1'b1; end
      ALU_SLT: begin d.op = OP_ADD; d.b_inv = 1'b1; d.slt = 1'b1; end
      ALU_NOR: begin d.op = OP_AND; d.a_inv = 1'b1; d.b_inv = 1'b1; end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, full adder,
// AND/OR/SUM/LESS select; set exposes the raw sum bit.
`timescale 1ns/1ps
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       a_inv,
  input  logic       b_inv,
  input  logic       cin,
  input  logic [1:0] op,
  input  logic       less,
  output logic       result,
  output logic       cout,
  output logic       set
);

  logic aa, bb, sum;

  assign aa   = a ^ a_inv;
  assign bb   = b ^ b_inv;
  assign sum  = aa ^ bb ^ cin;
  assign cout = (aa & bb) | (aa & cin) | (bb & cin);
  assign set  = sum;

  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = aa & bb;
      OP_OR:   result = aa | bb;
      OP_ADD:  result = sum;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one slice, LSB first, one bit per clock, SLT fix-up.
// Optional macro SLT_OVF_FIX_EN: SLT compares correctly under signed overflow.
`timescale 1ns/1ps
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh;
  dec_t             dec, dec_in;
  logic             less_q, less_nx;
  logic             last, msb_ovf;
  logic             slice_res, slice_cout, slice_set;

  assign dec_in  = decode(ctrl_i);
  assign last    = (state == RUN) && (cnt == CNT_LAST);
  assign msb_ovf = carry ^ slice_cout;

`ifdef SLT_OVF_FIX_EN
  assign less_nx = slice_set ^ msb_ovf;
`else
  assign less_nx = slice_set;
`endif

  alu_bit_slice u_slice (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .a_inv  (dec.a_inv),
    .b_inv  (dec.b_inv),
    .cin    (carry),
    .op     (dec.op),
    .less   (1'b0),
    .result (slice_res),
    .cout   (slice_cout),
    .set    (slice_set)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = RUN;
      RUN:     if (last) state_nx = dec.slt ? FIX : DONE;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == RUN) || (state == FIX);
    done_o = (state == DONE);
  end

  // Counter, carry chain and architecturally visible result/flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt        <= '0;
      carry      <= 1'b0;
      result_o   <= '0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          cnt        <= '0;
          carry      <= dec_in.b_inv && (dec_in.op == OP_ADD);
          result_o   <= '0;
          cout_o     <= 1'b0;
          overflow_o <= 1'b0;
        end
        RUN: begin
          result_o[cnt] <= dec.valid & slice_res;
          carry         <= slice_cout;
          cnt           <= cnt + 1'b1;
          if (last) begin
            cout_o     <= dec.arith & slice_cout;
            overflow_o <= dec.arith & msb_ovf;
          end
        end
        FIX:     result_o <= {{(WIDTH-1){1'b0}}, less_q};
        default: ;
      endcase
    end
  end

  // Operand shift registers and captured decode carry no reset
  always_ff @(posedge clk_i) begin
    if (state == IDLE && start_i) begin
      a_sh <= src1_i;
      b_sh <= src2_i;
      dec  <= dec_in;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      if (last) less_q <= less_nx;
    end
  end

  assign zero_o = (result_o == '0);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl (WIDTH=32).
`timescale 1ns/1ps
module tb_alu_serial_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic [3:0]   ctrl_i = 4'b0000;
  logic         busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [W-1:0] result_o;

  int checks = 0;
  int errors = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .ctrl_i     (ctrl_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .cout_o     (cout_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the IDLE cycle after done.
  task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_cout, input logic exp_ovf, input int exp_lat);
    int n;
    start_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    src1_i = ~a; src2_i = ~b;
    n = 1;
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    while (!done_o && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_zero"}, 32'(zero_o), 32'(exp_res == 32'd0));
    check({tag, "_cout"}, 32'(cout_o), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(overflow_o), 32'(exp_ovf));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_hold"}, result_o, exp_res);
  endtask

  initial begin
    int pulses;
    logic [31:0] slt_ovf_exp;
`ifdef SLT_OVF_FIX_EN
    slt_ovf_exp = 32'h0000_0000;
`else
    slt_ovf_exp = 32'h0000_0001;
`endif

    #1;
    check("rst_res", result_o, 32'd0);
    check("rst_zero", 32'(zero_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_cout", 32'(cout_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, W+1);
    do_op("sub_eq",  4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, W+1);
    do_op("nor_b2b", 4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, W+1);
    do_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, W+2);
    do_op("slt_pos", 4'b0111, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, W+2);
    do_op("slt_ovf", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, slt_ovf_exp,   1'b0, 1'b0, W+2);
    do_op("and",     4'b0000, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 1'b0, 1'b0, W+1);
    do_op("or",      4'b0001, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'hFCFC_FCFC, 1'b0, 1'b0, W+1);
    do_op("add_wrap",4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, W+1);
    do_op("sub_neg", 4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, W+1);
    do_op("unsup",   4'b1111, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0, 1'b0, W+1);

    // start held high with changing operands: only the first request runs
    start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd1; src2_i = 32'd1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      src1_i = $urandom; src2_i = $urandom; ctrl_i = 4'b0110;
      @(posedge clk);
    end
    @(negedge clk);
    start_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) pulses++;
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_res", result_o, 32'd2);

    // asynchronous reset in the middle of RUN
    start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'h1234_5678; src2_i = 32'd1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_res", result_o, 32'd0);
    check("arst_zero", 32'(zero_o), 32'd1);
    check("arst_cout", 32'(cout_o), 32'd0);
    check("arst_ovf", 32'(overflow_o), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) pulses++;
    end
    rst_i = 1'b1;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) pulses++;
    end
    check("arst_no_done", 32'(pulses), 32'd0);
    check("arst_idle_busy", 32'(busy_o), 32'd0);

    do_op("add_post", 4'b0010, 32'd3, 32'd4, 32'h0000_0007, 1'b0, 1'b0, W+1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
